// File: rtl/dcache_snoop_ctrl.sv
// dcache_snoop_ctrl: per-CPU MSI coherence controller. Holds tag and MSI
// state per direct-mapped line, turns CPU misses/upgrades into bus requests
// and services snoop searches and invalidations from the arbiter.
module dcache_snoop_ctrl #(
  parameter int LINES       = 8,
  parameter int OFFSET_W    = 2,
  parameter int FILL_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cpu_rd,
  input  logic        cpu_wr,
  input  logic [12:0] cpu_addr,
  output logic        cpu_hit,
  output logic        cpu_stall,
  output logic        read_miss,
  output logic        write_miss,
  output logic        invalidate,
  output logic [12:0] bico,
  input  logic        bus_ack,
  input  logic        search,
  input  logic [12:0] boci,
  input  logic        inv_from_other,
  output logic        search_found,
  output logic [1:0]  block_state,
  input  logic [1:0]  datasel,
  output logic [1:0]  fill_src
);

  localparam int INDEX_W = $clog2(LINES);
  localparam int TAG_W   = 13 - OFFSET_W - INDEX_W;

  localparam logic [1:0] ST_I = 2'b00;
  localparam logic [1:0] ST_S = 2'b01;
  localparam logic [1:0] ST_M = 2'b10;

  typedef enum logic [2:0] {IDLE, REQ_RD, REQ_WR, REQ_INV, FILL} fsm_t;

  fsm_t               r_fsm, w_fsm_next;
  logic [1:0]         r_st  [LINES];
  logic [TAG_W-1:0]   r_tag [LINES];
  logic [12:0]        r_bico;
  logic [2:0]         r_cnt;
  logic               r_fill_wr;
  logic               r_read_miss, r_write_miss, r_invalidate;
  logic               r_search_found;
  logic [1:0]         r_fill_src;

  // CPU-side lookup
  logic [INDEX_W-1:0] w_c_idx;
  logic [TAG_W-1:0]   w_c_tag;
  logic [1:0]         w_c_st;
  logic               w_c_hit;
  // Snoop-side lookup
  logic [INDEX_W-1:0] w_s_idx;
  logic [TAG_W-1:0]   w_s_tag;
  logic [1:0]         w_s_st;
  logic               w_s_hit;
  // Outstanding-request line
  logic [INDEX_W-1:0] w_b_idx;
  logic [TAG_W-1:0]   w_b_tag;

  logic               w_cpu_hit, w_latch_bico, w_install, w_upgrade, w_load_cnt;
  logic               w_inv_race;
  logic               w_unused;

  assign w_c_idx  = cpu_addr[OFFSET_W +: INDEX_W];
  assign w_c_tag  = cpu_addr[12 -: TAG_W];
  assign w_c_st   = r_st[w_c_idx];
  assign w_c_hit  = (r_tag[w_c_idx] == w_c_tag) && (w_c_st != ST_I);

  assign w_s_idx  = boci[OFFSET_W +: INDEX_W];
  assign w_s_tag  = boci[12 -: TAG_W];
  assign w_s_st   = r_st[w_s_idx];
  assign w_s_hit  = (r_tag[w_s_idx] == w_s_tag) && (w_s_st != ST_I);

  assign w_b_idx  = r_bico[OFFSET_W +: INDEX_W];
  assign w_b_tag  = r_bico[12 -: TAG_W];

  // The other CPU invalidated the very line we are trying to upgrade.
  assign w_inv_race = inv_from_other && w_s_hit &&
                      (boci[12:OFFSET_W] == r_bico[12:OFFSET_W]);

  // Offset bits select a word within the block; the block itself ignores them.
  assign w_unused = ^{cpu_addr[OFFSET_W-1:0], boci[OFFSET_W-1:0]};

  // Next-state and per-cycle control decode
  // NOTE: every signal driven here gets a default first, so no path can leave one unassigned and infer a latch.
  always_comb begin
    w_fsm_next   = r_fsm;
    w_cpu_hit    = 1'b0;
    w_install    = 1'b0;
    w_upgrade    = 1'b0;
    w_load_cnt   = 1'b0;
    unique case (r_fsm)
      IDLE: begin
        if (cpu_rd) begin
          if (w_c_hit) w_cpu_hit  = 1'b1;
          else         w_fsm_next = REQ_RD;
        end else if (cpu_wr) begin
          if (w_c_hit && (w_c_st == ST_M)) w_cpu_hit  = 1'b1;
          else if (w_c_hit)                w_fsm_next = REQ_INV;
          else                             w_fsm_next = REQ_WR;
        end
      end
      REQ_RD, REQ_WR: begin
        if (bus_ack) begin
          w_load_cnt = 1'b1;
          w_fsm_next = FILL;
        end
      end
      REQ_INV: begin
        // Losing the line to the other CPU outranks an ack for the upgrade.
        if (w_inv_race) begin
          w_fsm_next = REQ_WR;
        end else if (bus_ack) begin
          w_upgrade  = 1'b1;
          w_fsm_next = IDLE;
        end
      end
      FILL: begin
        if (r_cnt == 3'd1) begin
          w_install  = 1'b1;
          w_fsm_next = IDLE;
        end
      end
      default: w_fsm_next = IDLE;
    endcase
    w_latch_bico = (r_fsm == IDLE) && (w_fsm_next != IDLE);
  end

  assign cpu_hit   = w_cpu_hit;
  assign cpu_stall = (r_fsm != IDLE) || ((cpu_rd || cpu_wr) && !w_cpu_hit);

  // FSM state, request outputs, fill counter and captured addresses
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_fsm        <= IDLE;
      r_bico       <= '0;
      r_cnt        <= '0;
      r_fill_wr    <= 1'b0;
      r_read_miss  <= 1'b0;
      r_write_miss <= 1'b0;
      r_invalidate <= 1'b0;
      r_fill_src   <= 2'b00;
    end else begin
      r_fsm        <= w_fsm_next;
      r_read_miss  <= (w_fsm_next == REQ_RD);
      r_write_miss <= (w_fsm_next == REQ_WR);
      r_invalidate <= (w_fsm_next == REQ_INV);
      if (w_latch_bico) r_bico <= cpu_addr;
      if (w_load_cnt) begin
        r_cnt     <= 3'(FILL_CYCLES);
        r_fill_wr <= (r_fsm == REQ_WR);
      end else if (r_fsm == FILL) begin
        r_cnt <= r_cnt - 3'd1;
      end
      if (w_install) r_fill_src <= datasel;
    end
  end

  // Registered snoop search result
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_search_found <= 1'b0;
    else     r_search_found <= search && w_s_hit;
  end

  // Line tag/state array; later statements take priority (install > upgrade > invalidate > demote)
  // NOTE: the array is small and held in flops, so it is reset explicitly to make every line I after rst.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < LINES; i++) begin
        r_st[i]  <= ST_I;
        r_tag[i] <= '0;
      end
    end else begin
      if (search && w_s_hit && (w_s_st == ST_M)) r_st[w_s_idx] <= ST_S;
      if (inv_from_other && w_s_hit)             r_st[w_s_idx] <= ST_I;
      if (w_upgrade)                             r_st[w_b_idx] <= ST_M;
      if (w_install) begin
        r_st[w_b_idx]  <= r_fill_wr ? ST_M : ST_S;
        r_tag[w_b_idx] <= w_b_tag;
      end
    end
  end

  assign read_miss    = r_read_miss;
  assign write_miss   = r_write_miss;
  assign invalidate   = r_invalidate;
  assign bico         = r_bico;
  assign search_found = r_search_found;
  assign block_state  = w_s_hit ? w_s_st : ST_I;
  assign fill_src     = r_fill_src;

endmodule
